// File: rtl/uart_mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters (optional abort: UART_ARB_TIMEOUT_EN).
// Latency: strobes 1 cycle after grant; rdy 1 cycle after mem_rdy; 3 cycles grant to grant at minimum.
// Backpressure: requests stay pending (level) until granted; BUSY holds until mem_rdy or timeout.
module uart_mem_port_arbiter #(
    parameter int NUM_BYTES_DATA    = 4,
    parameter int NUM_BYTES_ADDRESS = 1,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           r0_we,
    input  logic [NUM_BYTES_DATA*8-1:0]    r0_wdata,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] r0_waddr,
    input  logic                           r0_re,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] r0_raddr,
    output logic [NUM_BYTES_DATA*8-1:0]    r0_rdata,
    output logic                           r0_rdy,
    output logic                           r0_err,
    input  logic                           r1_we,
    input  logic [NUM_BYTES_DATA*8-1:0]    r1_wdata,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] r1_waddr,
    input  logic                           r1_re,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] r1_raddr,
    output logic [NUM_BYTES_DATA*8-1:0]    r1_rdata,
    output logic                           r1_rdy,
    output logic                           r1_err,
    output logic                           mem_we,
    output logic                           mem_re,
    output logic [NUM_BYTES_DATA*8-1:0]    mem_wdata,
    output logic [NUM_BYTES_ADDRESS*8-1:0] mem_waddr,
    output logic [NUM_BYTES_ADDRESS*8-1:0] mem_raddr,
    input  logic [NUM_BYTES_DATA*8-1:0]    mem_rdata,
    input  logic                           mem_rdy
);
    localparam int D = NUM_BYTES_DATA * 8;
    localparam int A = NUM_BYTES_ADDRESS * 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nxt;
    logic           prio, gnt_id, grant_id, grant;
    logic           done_ok, timeout_hit, to_expire;
    logic           pend0, pend1;
    logic           cap_we, cap_re;
    logic [D-1:0]   cap_wdata;
    logic [A-1:0]   cap_waddr, cap_raddr;
    logic           sel_we, sel_re;
    logic [D-1:0]   sel_wdata;
    logic [A-1:0]   sel_waddr, sel_raddr;

    assign pend0     = r0_we | r0_re;
    assign pend1     = r1_we | r1_re;
    assign sel_we    = grant_id ? r1_we    : r0_we;
    assign sel_re    = grant_id ? r1_re    : r0_re;
    assign sel_wdata = grant_id ? r1_wdata : r0_wdata;
    assign sel_waddr = grant_id ? r1_waddr : r0_waddr;
    assign sel_raddr = grant_id ? r1_raddr : r0_raddr;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        grant_id    = prio;
        done_ok     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                    if (!(pend0 && pend1)) grant_id = pend1;
                end
            end
            BUSY: begin
                // A late mem_rdy still wins over an expiring timeout.
                if (mem_rdy) begin
                    done_ok   = 1'b1;
                    state_nxt = DONE;
                end else if (to_expire) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prio      <= 1'b0;
            gnt_id    <= 1'b0;
            cap_we    <= 1'b0;
            cap_re    <= 1'b0;
            cap_wdata <= '0;
            cap_waddr <= '0;
            cap_raddr <= '0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            if (grant) begin
                gnt_id    <= grant_id;
                cap_we    <= sel_we;
                cap_re    <= sel_re & ~sel_we;
                cap_wdata <= sel_wdata;
                cap_waddr <= sel_waddr;
                cap_raddr <= sel_raddr;
            end
            if (done_ok || timeout_hit) prio <= ~gnt_id;
            if (done_ok && cap_re) begin
                if (gnt_id) r1_rdata <= mem_rdata;
                else        r0_rdata <= mem_rdata;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;
    logic          err_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (grant)                          to_cnt <= '0;
            else if (state == BUSY && !mem_rdy) to_cnt <= to_cnt + CW'(1);
            if (grant)            err_q <= 1'b0;
            else if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign to_expire = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign r0_err    = r0_rdy & err_q;
    assign r1_err    = r1_rdy & err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign to_expire = 1'b0;
    assign r0_err    = 1'b0;
    assign r1_err    = 1'b0;
`endif

    assign mem_we    = (state == BUSY) & cap_we;
    assign mem_re    = (state == BUSY) & cap_re;
    assign mem_wdata = cap_wdata;
    assign mem_waddr = cap_waddr;
    assign mem_raddr = cap_raddr;
    assign r0_rdy    = (state == DONE) & ~gnt_id;
    assign r1_rdy    = (state == DONE) & gnt_id;
endmodule

// File: doc/uart_mem_port_arbiter.md
# uart_mem_port_arbiter

Two-requester arbiter that shares one memory port between the UART memory-mapped bridge and a second master, such as a host CPU or DMA. It sits between the requesters and the memory, using the same mem_we/mem_re/mem_rdy handshake on both sides. It grants one transaction at a time with round-robin fairness and returns read data and completion to the granted requester only.

## Interface
- NUM_BYTES_DATA, 4, data width in bytes (D = NUM_BYTES_DATA*8)
- NUM_BYTES_ADDRESS, 1, address width in bytes (A = NUM_BYTES_ADDRESS*8)
- TIMEOUT_CYCLES, 255, BUSY cycles before abort (used only with UART_ARB_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- arst_n  in  1  asynchronous, active-low reset
- rN_we  in  1  requester N write request, level, N in {0,1}
- rN_wdata  in  D  requester N write data
- rN_waddr  in  A  requester N write address
- rN_re  in  1  requester N read request, level
- rN_raddr  in  A  requester N read address
- rN_rdata  out  D  read data returned to requester N
- rN_rdy  out  1  one-cycle completion pulse to requester N
- rN_err  out  1  with rN_rdy: transaction aborted by timeout
- mem_we, mem_re  out  1  memory write/read strobes, held for the whole transaction
- mem_wdata  out  D; mem_waddr, mem_raddr  out  A
- mem_rdata  in  D  memory read data, valid with mem_rdy
- mem_rdy  in  1  memory completion pulse

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: a requester is pending when rN_we | rN_re.
  - One pending: grant it.
  - Both pending: grant the requester selected by the prio register.
  - On grant, capture the granted requester's we/re/addresses/wdata into internal registers, latch gnt_id, go to BUSY.
- Requester asserts both we and re: treated as a write; re is ignored for that transaction.
- BUSY: mem_* outputs are driven from the captured registers, never combinationally from requester inputs. Requester inputs may change freely after grant.
  - On mem_rdy: load r<gnt_id>_rdata with mem_rdata (reads only; writes leave rdata unchanged), set prio = ~gnt_id, go to DONE.
- DONE (exactly one cycle):
  - r<gnt_id>_rdy = 1; mem_we = mem_re = 0.
  - Go to IDLE.
  - The requester must deassert its request in the cycle following rdy, so it is not regranted.
- mem_rdy is ignored in IDLE and DONE.
- The non-granted requester's outputs never change during a transaction.
- rN_rdata holds its value until the next completed read by requester N.

## Timing
- Reset values: state = IDLE, prio = 0 (r0 preferred), gnt_id = 0.
- Reset values of outputs: all rN_rdy/rN_err/rN_rdata = 0, all mem_* outputs = 0, timeout counter = 0.
- Request sampled in IDLE at edge k: mem_we/mem_re asserted from cycle k+1.
- mem_rdy sampled high at edge m: from cycle m+1, rN_rdy = 1 for exactly one cycle, rN_rdata is valid, and mem strobes are 0. State returns to IDLE at m+2.
- Minimum transaction, with mem_rdy in the first BUSY cycle: 3 cycles, grant to grant.
- Back-to-back requests from the same requester alone: served every 3 cycles; prio toggling does not block it.
- Reset mid-transaction: immediate return to reset values. No rdy is issued, and the in-flight access is abandoned.
- mem_rdy and a new request in the same cycle: the new request waits; it is evaluated only in IDLE.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments on each BUSY cycle without mem_rdy.
  - On reaching TIMEOUT_CYCLES: go to DONE with r<gnt_id>_rdy = 1 and r<gnt_id>_err = 1; rdata is unchanged; prio toggles.
  - mem_rdy in the same cycle as the timeout takes precedence: normal completion, err = 0.
- UART_ARB_TIMEOUT_EN undefined: no counter; rN_err is tied to 0; BUSY waits indefinitely for mem_rdy.

## Test plan
- Single r0 write: r0_we=1, waddr=0x10, wdata=0xDEADBEEF; mem_rdy 2 cycles after mem_we.
  - mem_we/waddr/wdata appear 1 cycle after request.
  - r0_rdy pulses once, 1 cycle after mem_rdy; r1_rdy stays 0.
- r1 read: r1_re=1, raddr=0x22; memory returns 0x12345678 with mem_rdy.
  - r1_rdata = 0x12345678 with r1_rdy; r0_rdata unchanged.
- Contention: r0 and r1 request continuously from reset.
  - Grant order r0, r1, r0, r1; each requester gets exactly one rdy per grant.
- Write+read same requester: r0_we=1 and r0_re=1.
  - Only mem_we asserted; mem_re stays 0.
- Reset mid-BUSY: assert arst_n=0 while mem_we=1.
  - All outputs 0 immediately; after release, a pending r1 request wins only if r0 is idle (prio = 0).
- Timeout (macro defined, TIMEOUT_CYCLES=4): r0 read, mem_rdy never asserted.
  - r0_rdy=1 and r0_err=1 after 4 BUSY cycles; mem_re drops; next grant goes to r1 if pending.
